// File: rtl/umem_master_pkg.sv
// Shared types and helpers for the unified-memory initiator (umem_master).
package umem_master_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    SZ_BYTE = 1'b0,
    SZ_WORD = 1'b1
  } size_e;

  localparam int WORD_BYTES = 4;

  // Big-endian lane k: lane 0 is the most significant byte.
  function automatic logic [7:0] be_lane(input logic [31:0] word, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      2'd3:    b = word[7:0];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/umem_master.sv
// Core-side initiator for the unified memory: one load/store at a time, word stores as 4 byte writes.
// Optional build macro UMEM_MASTER_ALIGN_CHECK_EN traps unaligned word requests with rsp_err.
module umem_master
  import umem_master_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rw,
  output logic [7:0]        mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_e              state_r, state_s;
  logic [1:0]          cnt_r, cnt_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic [31:0]         wdata_r, wdata_s;
  size_e               size_r, size_s;
  logic [ADDR_W-1:0]   mem_addr_r, mem_addr_s;
  logic                mem_rw_r, mem_rw_s;
  logic [7:0]          mem_wdata_r, mem_wdata_s;
  logic                rsp_valid_r, rsp_valid_s;
  logic [31:0]         rsp_rdata_r, rsp_rdata_s;
  logic                rsp_err_r, rsp_err_s;
  logic                req_ready_r, req_ready_s;
  logic                trap_s;

`ifdef UMEM_MASTER_ALIGN_CHECK_EN
  assign trap_s = (req_size == 1'b1) && (req_addr[1:0] != 2'b00);
`else
  assign trap_s = 1'b0;
`endif

  // Next-state and next-output logic; every output is registered so mem_* never sees req_* combinationally.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    addr_s      = addr_r;
    wdata_s     = wdata_r;
    size_s      = size_r;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    mem_rw_s    = 1'b0;
    rsp_rdata_s = 32'h0;
    rsp_err_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          addr_s  = req_addr;
          wdata_s = req_wdata;
          size_s  = size_e'(req_size);
          cnt_s   = 2'd0;
          if (trap_s) begin
            state_s   = RESP;
            rsp_err_s = 1'b1;
          end else if (req_we) begin
            state_s     = STORE;
            mem_addr_s  = req_addr;
            mem_rw_s    = 1'b1;
            mem_wdata_s = (req_size == 1'b1) ? be_lane(req_wdata, 2'd0) : req_wdata[7:0];
          end else begin
            state_s    = LOAD;
            mem_addr_s = req_addr;
          end
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        state_s     = RESP;
        rsp_rdata_s = (size_r == SZ_WORD) ? mem_rdata : {24'h0, mem_rdata[31:24]};
      end
      STORE: begin
        if ((size_r == SZ_BYTE) || (cnt_r == 2'(WORD_BYTES - 1))) begin
          state_s = RESP;
        end else begin
          cnt_s       = cnt_r + 2'd1;
          mem_addr_s  = addr_r + ADDR_W'(cnt_s);
          mem_wdata_s = be_lane(wdata_r, cnt_s);
          mem_rw_s    = 1'b1;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    rsp_valid_s = (state_s == RESP);
    req_ready_s = (state_s == IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= 2'd0;
      addr_r      <= '0;
      wdata_r     <= 32'h0;
      size_r      <= SZ_BYTE;
      mem_addr_r  <= '0;
      mem_rw_r    <= 1'b0;
      mem_wdata_r <= 8'h0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0;
      rsp_err_r   <= 1'b0;
      req_ready_r <= 1'b1;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      addr_r      <= addr_s;
      wdata_r     <= wdata_s;
      size_r      <= size_s;
      mem_addr_r  <= mem_addr_s;
      mem_rw_r    <= mem_rw_s;
      mem_wdata_r <= mem_wdata_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_rdata_r <= rsp_rdata_s;
      rsp_err_r   <= rsp_err_s;
      req_ready_r <= req_ready_s;
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;
  assign mem_addr  = mem_addr_r;
  assign mem_rw    = mem_rw_r;
  assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_umem_master.sv
// Self-checking bench for umem_master: transaction-level model predicts every cycle's outputs.
module tb_umem_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_size;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        req_ready, rsp_valid, rsp_err, mem_rw;
  logic [31:0] rsp_rdata, mem_rdata;
  logic [7:0]  mem_addr, mem_wdata;

  logic [7:0] env_mem [256];
  logic [7:0] ref_mem [256];

  int checks = 0;
  int errors = 0;
  int accepts = 0;
  int rsps = 0;

  umem_master #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory environment: big-endian combinational read, zero while writing.
  assign mem_rdata = mem_rw ? 32'h0 :
    {env_mem[mem_addr], env_mem[mem_addr + 8'd1], env_mem[mem_addr + 8'd2], env_mem[mem_addr + 8'd3]};

  typedef struct packed {
    bit          ready;
    bit          rw;
    bit          chk_addr;
    bit          full;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    bit          rsp;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t q[$];
  exp_t cur;

  function automatic exp_t mk(bit ready, bit rw, bit chk_addr, bit full, logic [7:0] a,
                              logic [7:0] d, bit rsp, logic [31:0] rd, bit err);
    exp_t r;
    r.ready = ready; r.rw = rw; r.chk_addr = chk_addr; r.full = full; r.addr = a;
    r.wdata = d; r.rsp = rsp; r.rdata = rd; r.err = err;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level expectation: list of per-cycle outputs following an accept.
  task automatic plan_txn(input bit we, input bit word, input logic [7:0] a, input logic [31:0] d);
    bit trap;
    trap = 1'b0;
`ifdef UMEM_MASTER_ALIGN_CHECK_EN
    trap = word && (a[1:0] != 2'b00);
`endif
    if (trap) begin
      q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 8'h0, 1'b1, 32'h0, 1'b1));
    end else if (we) begin
      for (int k = 0; k < (word ? 4 : 1); k++) begin
        logic [31:0] sh;
        sh = word ? (d >> (8 * (3 - k))) : d;
        q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 8'(a + k), sh[7:0], 1'b0, 32'h0, 1'b0));
      end
      q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 8'h0, 1'b1, 32'h0, 1'b0));
    end else begin
      logic [31:0] v;
      v = word ? {ref_mem[a], ref_mem[8'(a + 1)], ref_mem[8'(a + 2)], ref_mem[8'(a + 3)]}
               : {24'h0, ref_mem[a]};
      q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, a, 8'h0, 1'b0, 32'h0, 1'b0));
      q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 8'h0, 1'b1, v, 1'b0));
    end
  endtask

  // Environment memory and its reference copy, preloaded identically.
  initial begin
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = 8'($urandom);
      ref_mem[i] = env_mem[i];
    end
    forever begin
      @(posedge clk);
      if (mem_rw) env_mem[mem_addr] <= mem_wdata;
    end
  end

  // Reference model advances one cycle per clock edge.
  initial begin
    cur = mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h0, 8'h0, 1'b0, 32'h0, 1'b0);
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete();
        cur = mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h0, 8'h0, 1'b0, 32'h0, 1'b0);
      end else begin
        if (cur.ready && req_valid) begin
          accepts++;
          plan_txn(req_we, req_size, req_addr, req_wdata);
        end
        if (q.size() > 0) cur = q.pop_front();
        else cur = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h0, 8'h0, 1'b0, 32'h0, 1'b0);
        if (cur.rw) ref_mem[cur.addr] = cur.wdata;
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("req_ready", 32'(req_ready), 32'(cur.ready));
      chk("mem_rw", 32'(mem_rw), 32'(cur.rw));
      chk("rsp_valid", 32'(rsp_valid), 32'(cur.rsp));
      if (cur.chk_addr || cur.full) chk("mem_addr", 32'(mem_addr), 32'(cur.addr));
      if (cur.rw || cur.full) chk("mem_wdata", 32'(mem_wdata), 32'(cur.wdata));
      if (cur.rsp || cur.full) begin
        chk("rsp_rdata", rsp_rdata, cur.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(cur.err));
      end
      if (rsp_valid) rsps++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  task automatic txn(input bit we, input bit sz, input logic [7:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output int lat, output bit err);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1; req_we = we; req_size = sz; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd  = rsp_rdata;
    err = rsp_err;
  endtask

  logic [31:0] rd;
  int          lat;
  bit          err;
  logic [7:0]  p0, p1, p2, p3;
  int          a0, r0, mism;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 1'b0;
    req_addr = 8'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Word store then word load.
    txn(1'b1, 1'b1, 8'h10, 32'hDEADBEEF, rd, lat, err);
    chk("wst_latency", 32'(lat), 32'd5);
    chk("wst_rdata", rd, 32'h0);
    chk("wst_b10", 32'(env_mem[8'h10]), 32'h0000_00DE);
    chk("wst_b11", 32'(env_mem[8'h11]), 32'h0000_00AD);
    chk("wst_b12", 32'(env_mem[8'h12]), 32'h0000_00BE);
    chk("wst_b13", 32'(env_mem[8'h13]), 32'h0000_00EF);
    txn(1'b0, 1'b1, 8'h10, 32'h0, rd, lat, err);
    chk("wld_latency", 32'(lat), 32'd2);
    chk("wld_rdata", rd, 32'hDEADBEEF);

    // Byte store then byte load.
    p1 = env_mem[8'h21];
    txn(1'b1, 1'b0, 8'h20, 32'h123456A5, rd, lat, err);
    chk("bst_latency", 32'(lat), 32'd2);
    chk("bst_b20", 32'(env_mem[8'h20]), 32'h0000_00A5);
    chk("bst_b21_untouched", 32'(env_mem[8'h21]), 32'(p1));
    txn(1'b0, 1'b0, 8'h20, 32'h0, rd, lat, err);
    chk("bld_rdata", rd, 32'h000000A5);

    // Word store across the top of the address space.
    p0 = env_mem[8'hFE]; p1 = env_mem[8'hFF]; p2 = env_mem[8'h00]; p3 = env_mem[8'h01];
    txn(1'b1, 1'b1, 8'hFE, 32'h01020304, rd, lat, err);
`ifdef UMEM_MASTER_ALIGN_CHECK_EN
    chk("trap_latency", 32'(lat), 32'd1);
    chk("trap_err", 32'(err), 32'd1);
    chk("trap_bFE", 32'(env_mem[8'hFE]), 32'(p0));
    chk("trap_b01", 32'(env_mem[8'h01]), 32'(p3));
`else
    chk("wrap_latency", 32'(lat), 32'd5);
    chk("wrap_err", 32'(err), 32'd0);
    chk("wrap_bFE", 32'(env_mem[8'hFE]), 32'h0000_0001);
    chk("wrap_bFF", 32'(env_mem[8'hFF]), 32'h0000_0002);
    chk("wrap_b00", 32'(env_mem[8'h00]), 32'h0000_0003);
    chk("wrap_b01", 32'(env_mem[8'h01]), 32'h0000_0004);
`endif

    // Reset in the middle of a word store.
    p2 = env_mem[8'h42]; p3 = env_mem[8'h43];
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 1'b1; req_addr = 8'h40; req_wdata = 32'hAABBCCDD;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_b40", 32'(env_mem[8'h40]), 32'h0000_00AA);
    chk("rst_b41", 32'(env_mem[8'h41]), 32'h0000_00BB);
    chk("rst_b42_untouched", 32'(env_mem[8'h42]), 32'(p2));
    chk("rst_b43_untouched", 32'(env_mem[8'h43]), 32'(p3));

    // Request held valid continuously, alternating store and load.
    a0 = accepts; r0 = rsps;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = i[0];
      req_size  = 1'($urandom_range(0, 1));
      req_addr  = 8'($urandom);
      req_wdata = $urandom;
    end
    @(negedge clk);
    req_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("held_rsp_per_accept", 32'(rsps - r0), 32'(accepts - a0));
    chk("held_progress", 32'((accepts - a0) > 30), 32'd1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 199) == 0);
      req_valid = ($urandom_range(0, 1) == 1);
      req_we    = 1'($urandom_range(0, 1));
      req_size  = 1'($urandom_range(0, 1));
      req_addr  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(252, 255)) : 8'($urandom);
      req_wdata = $urandom;
    end
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    repeat (10) @(negedge clk);

    mism = 0;
    for (int i = 0; i < 256; i++) begin
      if (env_mem[i] !== ref_mem[i]) mism++;
    end
    chk("memory_image", 32'(mism), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
